// File: rtl/visca_cmd_sender_pkg.sv
// Shared definitions for the VISCA command sender: terminator byte,
// command indices, FSM state encoding and the length legality helper.
package visca_cmd_sender_pkg;

  localparam logic [7:0] VISCA_TERM = 8'hFF;

  localparam int CMD_ZOOM_STOP = 0;
  localparam int CMD_ZOOM_TELE = 1;
  localparam int CMD_ZOOM_WIDE = 2;
  localparam int CMD_INQ       = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // A length is legal when it is non-zero and addresses a ROM word (1..2^aw-1).
  // The comparison is unsigned on the full 8-bit length byte.
  function automatic logic len_legal(input logic [7:0] len, input int aw);
    return (len != 8'd0) && (32'(len) <= 32'((1 << aw) - 1));
  endfunction

endpackage

// File: rtl/visca_cmd_sender_if.sv
// Byte stream from the command sender to the camera UART transmitter.
// Handshake: a byte transfers on a clock edge where tx_valid & tx_ready.
// Once tx_valid is raised, tx_data and tx_valid stay stable until that
// transfer; tx_ready may change freely and never depends on tx_valid.
interface visca_cmd_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/visca_cmd_sender_rom_mux.sv
// Picks one command ROM's async output byte by the latched command index.
// Out-of-range indices read as zero (the FSM rejects them separately).
module visca_cmd_sender_rom_mux #(
  parameter int CMD_N  = 4,
  parameter int CMD_SW = 2
) (
  input  logic [CMD_N*8-1:0] rom_dout_i,
  input  logic [CMD_SW-1:0]  sel_i,
  output logic [7:0]         byte_o
);

  // Slice selection over all attached ROMs.
  always_comb begin
    byte_o = 8'h00;
    for (int k = 0; k < CMD_N; k++) begin
      if (sel_i == CMD_SW'(k)) byte_o = rom_dout_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/visca_cmd_sender.sv
// Serialises a VISCA command stored reversed in a small async ROM
// (length at address 0, first wire byte at address len) onto the UART
// byte stream, then holds off new requests for GAP_CYC idle clocks.
module visca_cmd_sender
  import visca_cmd_sender_pkg::*;
#(
  parameter int CMD_N   = 4,
  parameter int CMD_SW  = 2,
  parameter int ROM_AW  = 3,
  parameter int GAP_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_req,
  input  logic [CMD_SW-1:0]    cmd_sel,
  output logic                 cmd_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic                 err_term,
  output logic [ROM_AW-1:0]    rom_ad,
  input  logic [CMD_N*8-1:0]   rom_dout,
  visca_cmd_sender_if.master   tx,
  output state_e               state_dbg
);

  localparam int GW = $clog2(GAP_CYC + 1);

  state_e            state_q;
  logic [CMD_SW-1:0] sel_q;
  logic [ROM_AW-1:0] idx_q;
  logic [GW-1:0]     gap_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              cmd_ack_q, busy_q, done_q, err_len_q, err_term_q;
  logic [7:0]        rom_byte;
  logic              sel_ok;

  visca_cmd_sender_rom_mux #(
    .CMD_N  (CMD_N),
    .CMD_SW (CMD_SW)
  ) u_rom_mux (
    .rom_dout_i (rom_dout),
    .sel_i      (sel_q),
    .byte_o     (rom_byte)
  );

  assign sel_ok = (32'(sel_q) < 32'(CMD_N));

  // Sequencer: request acceptance, length check, byte walk from idx=len
  // down to 1, then the post-command gap. idx_q doubles as the ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_term_q <= 1'b0;
    end else begin
      cmd_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_term_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (cmd_req) begin
            sel_q     <= cmd_sel;
            cmd_ack_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (!sel_ok || !len_legal(rom_byte, ROM_AW)) begin
            err_len_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            idx_q   <= rom_byte[ROM_AW-1:0];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_data_q  <= rom_byte;
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          // tx_valid_q is always high here, so tx_ready alone completes the transfer.
          if (tx.tx_ready) begin
            tx_valid_q <= 1'b0;
            if (idx_q == ROM_AW'(1)) begin
              done_q     <= 1'b1;
              err_term_q <= (tx_data_q != VISCA_TERM);
              gap_q      <= GW'(GAP_CYC - 1);
              idx_q      <= '0;
              state_q    <= ST_GAP;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ack     = cmd_ack_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_len_q;
  assign err_term    = err_term_q;
  assign rom_ad      = idx_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign state_dbg   = state_q;

endmodule
